toast_timer: RTL and testbench
==============================

# toast_timer

Countdown controller for the toaster front panel. It holds a toast-time setpoint in seconds and lets the user adjust it with debounced buttons. On start it drives the heater for that many seconds, counting down in BCD. It produces the tens and ones digit codes consumed directly by the two-digit 7-segment decoder stage.

## Interface
Parameters:
- CLK_HZ, 50_000_000, clock cycles per displayed second; must be ≥ 2.
- MAX_SEC, 99, setpoint upper bound; range 1..99.
- DEF_SEC, 30, setpoint loaded at reset; range 1..MAX_SEC.
- DONE_SEC, 3, seconds the DONE indication is held before returning to IDLE; must be ≥ 1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- btn_up  in  1  one-cycle pulse, already debounced; increments the setpoint.
- btn_down  in  1  one-cycle pulse, already debounced; decrements the setpoint.
- btn_start  in  1  one-cycle pulse; starts toasting.
- btn_cancel  in  1  one-cycle pulse; aborts toasting or DONE.
- LEDt  out  4  left digit code for the decoder: BCD tens, or 4'hA ('t') in DONE.
- LEDc  out  4  right digit code for the decoder: BCD ones.
- heat  out  1  heater enable.
- done  out  1  high while in DONE.

## Operation
- State machine has three states: IDLE, TOAST, DONE. Reset enters IDLE.
- Reset values:
  - state IDLE; setpoint = DEF_SEC (BCD).
  - remaining = 0; prescaler = 0.
  - heat = 0; done = 0; LEDt/LEDc = DEF_SEC tens/ones.
- Setpoint and remaining are stored as two BCD digits each; no binary-to-BCD division.
  - Increment carries ones 9→0 into tens; decrement borrows ones 0→9 from tens.
- IDLE:
  - btn_up raises setpoint by 1, saturating at MAX_SEC.
  - btn_down lowers setpoint by 1, saturating at 1.
  - btn_up and btn_down together: no change.
  - Display shows the setpoint.
- IDLE + btn_start (and no btn_cancel):
  - remaining ← setpoint, prescaler ← 0, go to TOAST.
- TOAST:
  - heat = 1; display shows remaining.
  - Prescaler counts 0..CLK_HZ−1; at terminal count it wraps and remaining decrements.
  - The decrement that takes remaining from 1 to 0 goes to DONE instead; remaining is left at 0.
  - btn_up, btn_down and btn_start are ignored.
- TOAST + btn_cancel: go to IDLE immediately; heat drops; setpoint is unchanged.
- DONE:
  - heat = 0, done = 1; LEDt = 4'hA, LEDc = 0.
  - Prescaler restarts at 0; after DONE_SEC full seconds, go to IDLE.
  - btn_cancel or btn_start returns to IDLE early; a start pulse here does not restart toasting.
  - btn_up and btn_down are ignored.
- Priority within one cycle: reset > btn_cancel > btn_start > btn_up/btn_down.
- The setpoint is preserved across toast cycles, so a repeat start reuses the last value.

## Timing
- All outputs are registered and change on the clk edge following the causing input.
- btn_start at edge N: heat = 1 and display = setpoint after edge N+1.
- First decrement occurs CLK_HZ cycles after entry to TOAST.
- Entry to DONE occurs exactly setpoint × CLK_HZ cycles after entry to TOAST; heat is high for exactly that many cycles.
- DONE lasts DONE_SEC × CLK_HZ cycles unless aborted.
- btn_cancel in TOAST: heat = 0 one edge later.
- Reset asserted mid-TOAST: heat = 0 and setpoint = DEF_SEC after the next edge.
- LEDt/LEDc never carry values 4'hB–4'hF. The only non-BCD value is 4'hA, and only in DONE.

## Test plan
Run all scenarios with CLK_HZ = 4, MAX_SEC = 99, DEF_SEC = 30, DONE_SEC = 3.
- Reset, then idle 10 cycles -> LEDt = 3, LEDc = 0, heat = 0, done = 0.
- From 30, 72 btn_up pulses -> display holds 99 (saturated). Then 98 btn_down pulses -> 01. One more btn_down -> stays 01. btn_up and btn_down in the same cycle -> unchanged.
- From 09, one btn_up -> 10 (carry). From 10, one btn_down -> 09 (borrow).
- Setpoint 03, btn_start -> heat high for exactly 12 cycles, display sequence 03, 02, 01. Then done = 1 with LEDt = A, LEDc = 0 for 12 cycles, then IDLE showing 03.
- Setpoint 05, btn_start, btn_cancel 6 cycles later -> heat = 0 next edge, IDLE showing 05. Repeat with btn_start and btn_cancel in the same cycle -> stays IDLE.
- Mid-TOAST reset pulse -> next edge: heat = 0, display 30. btn_up during TOAST -> ignored.

Source files
------------

// File: rtl/toast_timer.sv
// ----------------------------------------------------------------------------
// toast_timer
//
// Countdown controller for the toaster front panel.
//
// It holds a toast-time setpoint (1..MAX_SEC seconds) as two BCD digits.
// The user adjusts the setpoint with debounced up/down pulses while idle.
// A start pulse loads the setpoint into the remaining-time register and
// enables the heater. The remaining time counts down once per CLK_HZ cycles.
// When time runs out the controller shows "t0" (4'hA, 0) for DONE_SEC
// seconds and then returns to idle.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   btn_up      1-cycle pulse: setpoint + 1 (saturates at MAX_SEC)
//   btn_down    1-cycle pulse: setpoint - 1 (saturates at 1)
//   btn_start   1-cycle pulse: start toasting
//   btn_cancel  1-cycle pulse: abort toasting / DONE
//   LEDt        left digit code (BCD tens, or 4'hA in DONE)
//   LEDc        right digit code (BCD ones)
//   heat        heater enable
//   done        high while in DONE
// ----------------------------------------------------------------------------
module toast_timer #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int MAX_SEC  = 99,
    parameter int DEF_SEC  = 30,
    parameter int DONE_SEC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_start,
    input  logic       btn_cancel,
    output logic [3:0] LEDt,
    output logic [3:0] LEDc,
    output logic       heat,
    output logic       done
);

    localparam int PW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DCW = (DONE_SEC > 1) ? $clog2(DONE_SEC) : 1;

    localparam logic [3:0] MAX_T = 4'(MAX_SEC / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_SEC % 10);
    localparam logic [3:0] DEF_T = 4'(DEF_SEC / 10);
    localparam logic [3:0] DEF_O = 4'(DEF_SEC % 10);
    localparam logic [3:0] CODE_T = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TOAST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      sp_t_q, sp_t_d, sp_o_q, sp_o_d;
    logic [3:0]      rem_t_q, rem_t_d, rem_o_q, rem_o_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DCW-1:0]  dcnt_q, dcnt_d;
    logic [3:0]      ledt_q, ledt_d, ledc_q, ledc_d;
    logic            heat_q, heat_d, done_q, done_d;

    logic            presc_tc;

    // Two-digit BCD increment and decrement. The result is packed as {tens, ones}.
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
        if (o == 4'd9) bcd_inc = {t + 4'd1, 4'd0};
        else           bcd_inc = {t, o + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
        if (o == 4'd0) bcd_dec = {t - 4'd1, 4'd9};
        else           bcd_dec = {t, o - 4'd1};
    endfunction

    assign presc_tc = (presc_q == PW'(CLK_HZ - 1));

    always_comb begin
        state_d = state_q;
        sp_t_d  = sp_t_q;
        sp_o_d  = sp_o_q;
        rem_t_d = rem_t_q;
        rem_o_d = rem_o_q;
        presc_d = presc_q;
        dcnt_d  = dcnt_q;

        case (state_q)
            S_IDLE: begin
                if (btn_cancel) begin
                    // Cancel outranks start: nothing happens while idle.
                    state_d = S_IDLE;
                end else if (btn_start) begin
                    rem_t_d = sp_t_q;
                    rem_o_d = sp_o_q;
                    presc_d = '0;
                    state_d = S_TOAST;
                end else if (btn_up && !btn_down) begin
                    if (!(sp_t_q == MAX_T && sp_o_q == MAX_O))
                        {sp_t_d, sp_o_d} = bcd_inc(sp_t_q, sp_o_q);
                end else if (btn_down && !btn_up) begin
                    if (!(sp_t_q == 4'd0 && sp_o_q == 4'd1))
                        {sp_t_d, sp_o_d} = bcd_dec(sp_t_q, sp_o_q);
                end
            end

            S_TOAST: begin
                if (btn_cancel) begin
                    presc_d = '0;
                    state_d = S_IDLE;
                end else if (presc_tc) begin
                    presc_d = '0;
                    // The last second ends in DONE. The decrement still runs,
                    // so remaining is left at 00.
                    {rem_t_d, rem_o_d} = bcd_dec(rem_t_q, rem_o_q);
                    if (rem_t_q == 4'd0 && rem_o_q == 4'd1) begin
                        dcnt_d  = '0;
                        state_d = S_DONE;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            S_DONE: begin
                if (btn_cancel || btn_start) begin
                    presc_d = '0;
                    state_d = S_IDLE;
                end else if (presc_tc) begin
                    presc_d = '0;
                    if (dcnt_q == DCW'(DONE_SEC - 1)) state_d = S_IDLE;
                    else                              dcnt_d  = dcnt_q + DCW'(1);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            default: begin
                presc_d = '0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are derived from the next state, so they are registered and
        // change on the same edge that samples the causing input.
        heat_d = (state_d == S_TOAST);
        done_d = (state_d == S_DONE);
        if (state_d == S_DONE) begin
            ledt_d = CODE_T;
            ledc_d = 4'd0;
        end else if (state_d == S_TOAST) begin
            ledt_d = rem_t_d;
            ledc_d = rem_o_d;
        end else begin
            ledt_d = sp_t_d;
            ledc_d = sp_o_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sp_t_q  <= DEF_T;
            sp_o_q  <= DEF_O;
            rem_t_q <= 4'd0;
            rem_o_q <= 4'd0;
            presc_q <= '0;
            dcnt_q  <= '0;
            ledt_q  <= DEF_T;
            ledc_q  <= DEF_O;
            heat_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_t_q  <= sp_t_d;
            sp_o_q  <= sp_o_d;
            rem_t_q <= rem_t_d;
            rem_o_q <= rem_o_d;
            presc_q <= presc_d;
            dcnt_q  <= dcnt_d;
            ledt_q  <= ledt_d;
            ledc_q  <= ledc_d;
            heat_q  <= heat_d;
            done_q  <= done_d;
        end
    end

    assign LEDt = ledt_q;
    assign LEDc = ledc_q;
    assign heat = heat_q;
    assign done = done_q;

endmodule

// File: tb/tb_toast_timer.sv
// ----------------------------------------------------------------------------
// tb_toast_timer
//
// Directed bench for toast_timer with CLK_HZ = 4. Each step drives the inputs
// on the falling edge and pushes the expected {LEDt, LEDc, heat, done} onto a
// scoreboard. After the next rising edge, the step pops that entry and
// compares it with the outputs on the following falling edge.
// ----------------------------------------------------------------------------
module tb_toast_timer;

    localparam int CLK_HZ   = 4;
    localparam int MAX_SEC  = 99;
    localparam int DEF_SEC  = 30;
    localparam int DONE_SEC = 3;

    logic       clk = 1'b0;
    logic       reset, btn_up, btn_down, btn_start, btn_cancel;
    logic [3:0] LEDt, LEDc;
    logic       heat, done;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   sp;          // bench model of the setpoint (decimal)

    toast_timer #(
        .CLK_HZ  (CLK_HZ),
        .MAX_SEC (MAX_SEC),
        .DEF_SEC (DEF_SEC),
        .DONE_SEC(DONE_SEC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_start (btn_start),
        .btn_cancel(btn_cancel),
        .LEDt      (LEDt),
        .LEDc      (LEDc),
        .heat      (heat),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] pack(input int t, input int c, input bit h, input bit d);
        pack = {4'(t), 4'(c), h, d};
    endfunction

    // One clock: drive inputs, record the expectation, then compare after the edge.
    task automatic step(input string tag, input bit rst, input bit up, input bit dn,
                        input bit st, input bit cn, input logic [9:0] expv);
        exp_t e, got;
        logic [9:0] obs;
        reset      = rst;
        btn_up     = up;
        btn_down   = dn;
        btn_start  = st;
        btn_cancel = cn;
        e.tag = tag;
        e.v   = expv;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        reset = 0; btn_up = 0; btn_down = 0; btn_start = 0; btn_cancel = 0;
        got = sb.pop_front();
        obs = {LEDt, LEDc, heat, done};
        n_cmp++;
        assert (obs === got.v) else begin
            n_bad++;
            $error("FAIL %s: observed LEDt=%h LEDc=%h heat=%b done=%b, expected LEDt=%h LEDc=%h heat=%b done=%b",
                   got.tag, obs[9:6], obs[5:2], obs[1], obs[0],
                   got.v[9:6], got.v[5:2], got.v[1], got.v[0]);
        end
        $display("step %-12s LEDt=%h LEDc=%h heat=%b done=%b", got.tag, LEDt, LEDc, heat, done);
    endtask

    function automatic logic [9:0] idle_exp(input int s);
        idle_exp = pack(s / 10, s % 10, 1'b0, 1'b0);
    endfunction

    initial begin
        reset = 1; btn_up = 0; btn_down = 0; btn_start = 0; btn_cancel = 0;
        @(negedge clk);

        // Reset, then idle.
        sp = DEF_SEC;
        step("reset", 1, 0, 0, 0, 0, idle_exp(sp));
        for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 0, 0, idle_exp(sp));

        // Saturating up, then down to 01, then the floor and the both-pressed case.
        for (int i = 0; i < 72; i++) begin
            sp = (sp < MAX_SEC) ? sp + 1 : MAX_SEC;
            step("up", 0, 1, 0, 0, 0, idle_exp(sp));
        end
        step("up_sat", 0, 1, 0, 0, 0, idle_exp(99));
        for (int i = 0; i < 98; i++) begin
            sp = (sp > 1) ? sp - 1 : 1;
            step("down", 0, 0, 1, 0, 0, idle_exp(sp));
        end
        step("down_sat", 0, 0, 1, 0, 0, idle_exp(1));
        step("up_and_dn", 0, 1, 1, 0, 0, idle_exp(1));

        // Carry 09->10 and borrow 10->09.
        for (int i = 0; i < 8; i++) begin
            sp++;
            step("up_to9", 0, 1, 0, 0, 0, idle_exp(sp));
        end
        step("carry", 0, 1, 0, 0, 0, idle_exp(10));
        step("borrow", 0, 0, 1, 0, 0, idle_exp(9));
        sp = 9;

        // Full toast from 03: 12 heat cycles, 12 DONE cycles, back to idle.
        for (int i = 0; i < 6; i++) begin
            sp--;
            step("down_to3", 0, 0, 1, 0, 0, idle_exp(sp));
        end
        for (int i = 0; i < sp * CLK_HZ; i++) begin
            int r;
            r = sp - i / CLK_HZ;
            step(i == 0 ? "start" : "toast", 0, 0, 0, i == 0, 0, pack(r / 10, r % 10, 1'b1, 1'b0));
        end
        for (int i = 0; i < DONE_SEC * CLK_HZ; i++)
            step("done", 0, 0, 0, 0, 0, pack(10, 0, 1'b0, 1'b1));
        step("after_done", 0, 0, 0, 0, 0, idle_exp(sp));

        // Setpoint 05, cancel 6 cycles after start.
        for (int i = 0; i < 2; i++) begin
            sp++;
            step("up_to5", 0, 1, 0, 0, 0, idle_exp(sp));
        end
        for (int i = 0; i < 6; i++) begin
            int r;
            r = sp - i / CLK_HZ;
            step(i == 0 ? "start5" : "toast5", 0, 0, 0, i == 0, 0, pack(r / 10, r % 10, 1'b1, 1'b0));
        end
        step("cancel", 0, 0, 0, 0, 1, idle_exp(5));
        step("post_cancel", 0, 0, 0, 0, 0, idle_exp(5));
        step("start+cncl", 0, 0, 0, 1, 1, idle_exp(5));
        step("still_idle", 0, 0, 0, 0, 0, idle_exp(5));

        // Button presses ignored during TOAST, then a reset mid-toast.
        step("start_b", 0, 0, 0, 1, 0, pack(0, 5, 1'b1, 1'b0));
        step("toast_b", 0, 0, 0, 0, 0, pack(0, 5, 1'b1, 1'b0));
        step("up_in_toast", 0, 1, 0, 0, 0, pack(0, 5, 1'b1, 1'b0));
        step("dn_in_toast", 0, 0, 1, 0, 0, pack(0, 5, 1'b1, 1'b0));
        step("toast_dec", 0, 0, 0, 0, 0, pack(0, 4, 1'b1, 1'b0));
        step("mid_reset", 1, 0, 0, 0, 0, idle_exp(DEF_SEC));
        step("post_reset", 0, 0, 0, 0, 0, idle_exp(DEF_SEC));

        // Early exit from DONE with a start pulse, which must not restart toasting.
        sp = DEF_SEC;
        for (int i = 0; i < 29; i++) begin
            sp--;
            step("down_to1", 0, 0, 1, 0, 0, idle_exp(sp));
        end
        for (int i = 0; i < CLK_HZ; i++)
            step(i == 0 ? "start1" : "toast1", 0, 0, 0, i == 0, 0, pack(0, 1, 1'b1, 1'b0));
        step("done1", 0, 0, 0, 0, 0, pack(10, 0, 1'b0, 1'b1));
        step("start_in_dn", 0, 0, 0, 1, 0, idle_exp(1));

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: observed %0d leftover entries, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
